// File: rtl/fir_step_bist_pkg.sv
// Shared types and constants for the FIR step-response self-test.
package fir_bist_pkg;

    localparam int MISR_WIDTH = 16;
    localparam logic [MISR_WIDTH-1:0] MISR_POLY_DEFAULT = 16'h1021;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DUT_RST,
        ST_STEP,
        ST_DRAIN,
        ST_DONE
    } bist_state_t;

    // One MISR step: shift left, apply feedback on carry-out, fold in data.
    function automatic logic [MISR_WIDTH-1:0] misr_next(
        input logic [MISR_WIDTH-1:0] sig,
        input logic [MISR_WIDTH-1:0] data,
        input logic [MISR_WIDTH-1:0] poly
    );
        return {sig[MISR_WIDTH-2:0], 1'b0} ^ (sig[MISR_WIDTH-1] ? poly : '0) ^ data;
    endfunction

endpackage

// File: rtl/fir_step_bist_misr16.sv
// 16-bit multiple-input signature register with synchronous clear and enable.
module misr16
    import fir_bist_pkg::*;
#(
    parameter logic [MISR_WIDTH-1:0] POLY = MISR_POLY_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [MISR_WIDTH-1:0] data,
    output logic [MISR_WIDTH-1:0] signature
);

    // Signature register: clear wins over a compaction step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            signature <= '0;
        end else if (clear) begin
            signature <= '0;
        end else if (enable) begin
            signature <= misr_next(signature, data, POLY);
        end
    end

endmodule

// File: rtl/fir_step_bist.sv
// Step-stimulus generator and MISR response checker placed beside a FIR.
module fir_step_bist
    import fir_bist_pkg::*;
#(
    parameter int                    WIDTH_DATA     = 8,
    parameter logic [WIDTH_DATA-1:0] STEP_VALUE     = WIDTH_DATA'(1),
    parameter int                    DUT_RST_CYCLES = 2,
    parameter int                    STEP_LEN       = 17,
    parameter int                    DRAIN_LEN      = 310,
    parameter logic [15:0]           MISR_POLY      = MISR_POLY_DEFAULT,
    parameter logic [15:0]           EXPECTED_SIG   = 16'h0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  fir_rst,
    output logic [WIDTH_DATA-1:0] fir_din,
    input  logic [WIDTH_DATA-1:0] fir_dout,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           signature,
    output logic [WIDTH_DATA-1:0] peak
);

    localparam int MAX_LEN = (DUT_RST_CYCLES > STEP_LEN)
        ? ((DUT_RST_CYCLES > DRAIN_LEN) ? DUT_RST_CYCLES : DRAIN_LEN)
        : ((STEP_LEN > DRAIN_LEN) ? STEP_LEN : DRAIN_LEN);
    localparam int CNT_W = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(DUT_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_LEN - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_LEN - 1);

    bist_state_t           state;
    bist_state_t           state_next;
    logic [CNT_W-1:0]      cnt;
    logic                  start_run;
    logic                  capture;
    logic                  in_run;
    logic [MISR_WIDTH-1:0] folded;
    logic [MISR_WIDTH-1:0] sig_next;

    // Fold the response sample down to the MISR width (zero-extend when narrower).
    always_comb begin
        folded = '0;
        for (int unsigned i = 0; i < WIDTH_DATA; i++) begin
            folded[i % MISR_WIDTH] = folded[i % MISR_WIDTH] ^ fir_dout[i];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; abort dominates start in every state.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start && !abort) state_next = ST_DUT_RST;
            end
            ST_DUT_RST: begin
                if (abort)                 state_next = ST_IDLE;
                else if (cnt == RST_LAST)  state_next = ST_STEP;
            end
            ST_STEP: begin
                if (abort)                 state_next = ST_IDLE;
                else if (cnt == STEP_LAST) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort)                  state_next = ST_IDLE;
                else if (cnt == DRAIN_LAST) state_next = ST_DONE;
            end
            ST_DONE: begin
                if (abort)      state_next = ST_IDLE;
                else if (start) state_next = ST_DUT_RST;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Run-control strobes derived from the current and next state.
    always_comb begin
        in_run    = (state == ST_DUT_RST) || (state == ST_STEP) || (state == ST_DRAIN);
        start_run = ((state == ST_IDLE) || (state == ST_DONE)) && (state_next == ST_DUT_RST);
        capture   = ((state == ST_STEP) || (state == ST_DRAIN)) && !abort;
        sig_next  = misr_next(signature, folded, MISR_POLY);
    end

    // Per-phase cycle counter, restarted on every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state_next != state) begin
            cnt <= '0;
        end else if (in_run) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered outputs decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fir_rst <= 1'b1;
            fir_din <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            peak    <= '0;
        end else begin
            fir_rst <= (state_next == ST_IDLE) || (state_next == ST_DUT_RST);
            fir_din <= ((state_next == ST_DUT_RST) || (state_next == ST_STEP)) ? STEP_VALUE : '0;
            busy    <= (state_next == ST_DUT_RST) || (state_next == ST_STEP) ||
                       (state_next == ST_DRAIN);
            done    <= (state_next == ST_DONE);
            // The last sample lands on the DONE-entry edge, so compare the
            // post-update signature rather than the registered one.
            if ((state_next == ST_DONE) && (state != ST_DONE)) begin
                pass <= (sig_next == EXPECTED_SIG);
            end else if (state_next != ST_DONE) begin
                pass <= 1'b0;
            end
            if (start_run) begin
                peak <= '0;
            end else if (capture && (fir_dout > peak)) begin
                peak <= fir_dout;
            end
        end
    end

    misr16 #(
        .POLY (MISR_POLY)
    ) u_misr (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_run),
        .enable    (capture),
        .data      (folded),
        .signature (signature)
    );

endmodule
